rv_uart_io_top: RTL and testbench

FPGA-top-level UART command responder for the RISC-V UART board.
- A 16x-oversampled UART receives a command byte and a 32-bit count N, sent LSB first.
- It then transmits a countdown N, N-1, ..., 0, one byte at a time. Each byte after the first is released by an acknowledge byte from the host.
- It also drives board I/O: LEDs, an 8-digit seven-segment display, a divided clock output and idle SPI pins.

---
 rtl/rv_uart_io_top.sv | 177 +++++++++++++++++
 tb/tb_rv_uart_io_top.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_uart_io_top.sv
// rtl/rv_uart_io_top.sv - UART countdown responder with LED, seven-segment and SPI-idle board I/O
module rv_uart_io_top #(
  parameter int BAUD_DIV = 56,
  parameter int SEG_DIV  = 100000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        rx,
  output logic        tx,
  input  logic        prog,
  input  logic        debug,
  input  logic [4:0]  debug_input,
  input  logic [95:0] key,
  input  logic        miso,
  output logic        mosi,
  output logic        cs,
  output logic        clk_out,
  output logic [6:0]  sev_out,
  output logic [7:0]  an,
  output logic [15:0] led
);
  localparam int BW = $clog2(BAUD_DIV + 1);
  localparam int SW = $clog2(SEG_DIV + 1);

  typedef enum logic [2:0] {P_IDLE, P_W0, P_W1, P_W2, P_W3, P_SEND, P_TXW, P_ACK} pstate_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

  pstate_t     ps_q, ps_d;
  rstate_t     rs_q, rs_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [2:0]  digit_q, digit_d;
  logic        clk_out_q, clk_out_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic [3:0]  rx_tick_q, rx_tick_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [3:0]  tx_bit_q, tx_bit_d, tx_tick_q, tx_tick_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  last_rx_q, last_rx_d;
  logic        baud_tick, seg_tick, rx_valid, tx_start;
  logic [3:0]  nib;
  logic        unused_pins;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      ps_q <= P_IDLE;       rs_q <= R_IDLE;
      baud_q <= '0;         seg_q <= '0;        digit_q <= '0;
      clk_out_q <= 1'b0;    rx_s1_q <= 1'b1;    rx_s2_q <= 1'b1;
      rx_tick_q <= '0;      rx_bit_q <= '0;     rx_sh_q <= '0;
      tx_q <= 1'b1;         tx_busy_q <= 1'b0;  tx_sh_q <= '1;
      tx_bit_q <= '0;       tx_tick_q <= '0;
      count_q <= '0;        last_rx_q <= '0;
    end else begin
      ps_q <= ps_d;         rs_q <= rs_d;
      baud_q <= baud_d;     seg_q <= seg_d;     digit_q <= digit_d;
      clk_out_q <= clk_out_d; rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d;
      rx_tick_q <= rx_tick_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
      tx_q <= tx_d;         tx_busy_q <= tx_busy_d; tx_sh_q <= tx_sh_d;
      tx_bit_q <= tx_bit_d; tx_tick_q <= tx_tick_d;
      count_q <= count_d;   last_rx_q <= last_rx_d;
    end
  end

  always_comb begin
    ps_d = ps_q;           rs_d = rs_q;
    rx_tick_d = rx_tick_q; rx_bit_d = rx_bit_q;  rx_sh_d = rx_sh_q;
    tx_d = tx_q;           tx_busy_d = tx_busy_q; tx_sh_d = tx_sh_q;
    tx_bit_d = tx_bit_q;   tx_tick_d = tx_tick_q;
    count_d = count_q;     last_rx_d = last_rx_q;
    digit_d = digit_q;
    rx_valid = 1'b0;
    tx_start = 1'b0;
    clk_out_d = ~clk_out_q;
    rx_s1_d = rx;
    rx_s2_d = rx_s1_q;
    baud_tick = (baud_q == BW'(BAUD_DIV - 1));
    baud_d = baud_tick ? '0 : baud_q + BW'(1);
    seg_tick = (seg_q == SW'(SEG_DIV - 1));
    seg_d = seg_tick ? '0 : seg_q + SW'(1);
    if (seg_tick) digit_d = digit_q + 3'd1;

    // Start is qualified at mid-bit, so every later sample lands mid-bit too.
    if (baud_tick) begin
      case (rs_q)
        R_IDLE: if (!rx_s2_q) begin rs_d = R_START; rx_tick_d = '0; end
        R_START:
          if (rx_tick_q == 4'd7) begin
            rx_tick_d = '0;
            rx_bit_d = '0;
            rs_d = rx_s2_q ? R_IDLE : R_DATA;
          end else rx_tick_d = rx_tick_q + 4'd1;
        R_DATA:
          if (rx_tick_q == 4'd15) begin
            rx_tick_d = '0;
            rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rs_d = R_STOP;
            else rx_bit_d = rx_bit_q + 3'd1;
          end else rx_tick_d = rx_tick_q + 4'd1;
        default:
          if (rx_tick_q == 4'd15) begin
            rs_d = R_IDLE;
            rx_valid = rx_s2_q;
          end else rx_tick_d = rx_tick_q + 4'd1;
      endcase
    end

    if (rx_valid) last_rx_d = rx_sh_q;
    case (ps_q)
      P_IDLE: if (rx_valid && rx_sh_q == 8'h00) ps_d = P_W0;
      P_W0:   if (rx_valid) begin count_d[7:0]   = rx_sh_q; ps_d = P_W1; end
      P_W1:   if (rx_valid) begin count_d[15:8]  = rx_sh_q; ps_d = P_W2; end
      P_W2:   if (rx_valid) begin count_d[23:16] = rx_sh_q; ps_d = P_W3; end
      P_W3:   if (rx_valid) begin count_d[31:24] = rx_sh_q; ps_d = P_SEND; end
      P_SEND: if (!tx_busy_q) begin tx_start = 1'b1; ps_d = P_TXW; end
      P_TXW:  if (!tx_busy_q) ps_d = (count_q == 32'd0) ? P_IDLE : P_ACK;
      default: if (rx_valid) begin count_d = count_q - 32'd1; ps_d = P_SEND; end
    endcase
    if (prog) begin
      ps_d = P_IDLE;
      count_d = count_q;
      tx_start = 1'b0;
    end

    // tx_sh_q[0] is the bit currently on the line; shifting in 1s keeps the tail idle-high.
    if (prog) begin
      tx_busy_d = 1'b0;
      tx_d = 1'b1;
    end else if (tx_busy_q) begin
      if (baud_tick) begin
        if (tx_tick_q == 4'd15) begin
          tx_tick_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_busy_d = 1'b0;
            tx_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_sh_d = {1'b1, tx_sh_q[9:1]};
            tx_d = tx_sh_q[1];
          end
        end else tx_tick_d = tx_tick_q + 4'd1;
      end
    end else if (tx_start) begin
      tx_busy_d = 1'b1;
      tx_sh_d = {1'b1, count_q[7:0], 1'b0};
      tx_bit_d = '0;
      tx_tick_d = '0;
      tx_d = 1'b0;
    end
  end

  assign nib = count_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    sev_out = 7'h7F;
    case (nib)
      4'h0: sev_out = 7'h40;  4'h1: sev_out = 7'h79;
      4'h2: sev_out = 7'h24;  4'h3: sev_out = 7'h30;
      4'h4: sev_out = 7'h19;  4'h5: sev_out = 7'h12;
      4'h6: sev_out = 7'h02;  4'h7: sev_out = 7'h78;
      4'h8: sev_out = 7'h00;  4'h9: sev_out = 7'h10;
      4'hA: sev_out = 7'h08;  4'hB: sev_out = 7'h03;
      4'hC: sev_out = 7'h46;  4'hD: sev_out = 7'h21;
      4'hE: sev_out = 7'h06;  default: sev_out = 7'h0E;
    endcase
  end

  assign an      = ~(8'h01 << digit_q);
  assign tx      = tx_q;
  assign clk_out = clk_out_q;
  assign mosi    = 1'b0;
  assign cs      = 1'b1;
  assign led     = debug ? {11'd0, debug_input} : {tx_busy_q, ps_q, 4'd0, last_rx_q};
  assign unused_pins = ^{key, miso};
endmodule

// File: tb/tb_rv_uart_io_top.sv
// tb/tb_rv_uart_io_top.sv - directed bench for rv_uart_io_top with a free-running tx decoder
module tb_rv_uart_io_top;
  localparam int BIT = 64;

  logic        clk = 1'b0;
  logic        Rst, rx, prog, debug, miso;
  logic [4:0]  debug_input;
  logic [95:0] key;
  logic        tx, mosi, cs, clk_out;
  logic [6:0]  sev_out;
  logic [7:0]  an;
  logic [15:0] led;
  logic [8:0]  txq[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  rv_uart_io_top #(.BAUD_DIV(4), .SEG_DIV(16)) dut (
    .clk(clk), .Rst(Rst), .rx(rx), .tx(tx), .prog(prog), .debug(debug),
    .debug_input(debug_input), .key(key), .miso(miso), .mosi(mosi), .cs(cs),
    .clk_out(clk_out), .sev_out(sev_out), .an(an), .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  // Decodes every tx frame whose start bit is still low at mid-bit; pushes {stop, data}.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (BIT / 2) @(negedge clk);
      if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        txq.push_back({tx, b});
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input int stop_len);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (stop_len) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (led[14:12] === s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_txq(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (txq.size() > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_an(input logic [7:0] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (an === want) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    logic prev;
    Rst = 1'b1; rx = 1'b1; prog = 1'b0; debug = 1'b0; debug_input = 5'd0;
    key = '0; miso = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({tx, mosi, cs, clk_out} !== 4'b1010) begin
      err_cnt++; $display("FAIL reset_pins: tx,mosi,cs,clk_out=%b want 1010", {tx, mosi, cs, clk_out});
    end
    vec_cnt++;
    if (an !== 8'hFE || sev_out !== 7'h40 || led !== 16'h0000) begin
      err_cnt++; $display("FAIL reset_disp: an=%h sev=%h led=%h want fe 40 0000", an, sev_out, led);
    end
    Rst = 1'b0;
    @(negedge clk);
    prev = clk_out;
    @(negedge clk);
    vec_cnt++;
    if (clk_out !== ~prev) begin
      err_cnt++; $display("FAIL clk_out_toggle: got %b want %b", clk_out, ~prev);
    end
    repeat (300) @(negedge clk);
    vec_cnt++;
    if (tx !== 1'b1 || led[14:12] !== 3'd0 || txq.size() != 0) begin
      err_cnt++; $display("FAIL idle_quiet: tx=%b state=%0d frames=%0d want 1 0 0", tx, led[14:12], txq.size());
    end
  endtask

  task automatic test_debug;
    debug = 1'b1; debug_input = 5'h15;
    @(negedge clk);
    vec_cnt++;
    if (led !== 16'h0015) begin
      err_cnt++; $display("FAIL debug_led: got %h want 0015", led);
    end
    debug = 1'b0;
  endtask

  task automatic test_countdown;
    bit ok;
    logic [8:0] got;
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h05, 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h00, 1'b1, BIT);
    vec_cnt++;
    if (led[15:12] !== 4'hE) begin
      err_cnt++; $display("FAIL cd_txw: busy,state=%h want e", led[15:12]);
    end
    wait_txq(1500, ok);
    got = ok ? txq.pop_front() : 9'h0;
    vec_cnt++;
    if (!ok || got !== 9'h105) begin
      err_cnt++; $display("FAIL cd_first: got %h (seen %0d) want 105", got, ok);
    end
    wait_state(3'd7, 300, ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++; $display("FAIL cd_ack: state=%0d want 7", led[14:12]);
    end
    wait_an(8'hFE, ok);
    vec_cnt++;
    if (!ok || sev_out !== 7'h12) begin
      err_cnt++; $display("FAIL cd_digit0: an=%h sev=%h want fe 12", an, sev_out);
    end
    for (int e = 4; e >= 0; e--) begin
      send_byte(8'h00, 1'b1, BIT);
      wait_txq(1500, ok);
      got = ok ? txq.pop_front() : 9'h0;
      vec_cnt++;
      if (!ok || got !== {1'b1, 8'(e)}) begin
        err_cnt++; $display("FAIL cd_byte%0d: got %h want %h", e, got, {1'b1, 8'(e)});
      end
    end
    wait_state(3'd0, 300, ok);
    repeat (800) @(negedge clk);
    vec_cnt++;
    if (!ok || led[14:12] !== 3'd0 || txq.size() != 0 || tx !== 1'b1) begin
      err_cnt++; $display("FAIL cd_end: state=%0d frames=%0d tx=%b want 0 0 1", led[14:12], txq.size(), tx);
    end
  endtask

  task automatic test_ignore_scan;
    bit ok;
    logic [8:0]  got;
    logic [31:0] val;
    logic [7:0]  want_an;
    val = 32'h12345678;
    send_byte(8'h3C, 1'b1, BIT);
    repeat (10) @(negedge clk);
    vec_cnt++;
    if (led[14:12] !== 3'd0 || led[7:0] !== 8'h3C) begin
      err_cnt++; $display("FAIL ignore_cmd: state=%0d last=%h want 0 3c", led[14:12], led[7:0]);
    end
    send_byte(8'h00, 1'b1, BIT);
    send_byte(8'h78, 1'b1, BIT);
    send_byte(8'h56, 1'b1, BIT);
    send_byte(8'h34, 1'b1, BIT);
    send_byte(8'h12, 1'b1, BIT);
    for (int i = 0; i < 8; i++) begin
      want_an = ~(8'h01 << i);
      wait_an(want_an, ok);
      vec_cnt++;
      if (!ok || sev_out !== seg_of(val[4*i +: 4])) begin
        err_cnt++; $display("FAIL scan_digit%0d: an=%h sev=%h want %h %h", i, an, sev_out, want_an, seg_of(val[4*i +: 4]));
      end
    end
    wait_txq(1500, ok);
    got = ok ? txq.pop_front() : 9'h0;
    vec_cnt++;
    if (!ok || got !== 9'h178) begin
      err_cnt++; $display("FAIL scan_tx: got %h want 178", got);
    end
    wait_state(3'd7, 300, ok);
  endtask

  task automatic test_prog;
    bit ok;
    send_byte(8'h00, 1'b1, 40);
    wait_state(3'd6, 100, ok);
    prog = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (!ok || tx !== 1'b1 || led[14:12] !== 3'd0) begin
      err_cnt++; $display("FAIL prog_abort: tx=%b state=%0d want 1 0", tx, led[14:12]);
    end
    prog = 1'b0;
    repeat (800) @(negedge clk);
    wait_an(8'hFE, ok);
    vec_cnt++;
    if (!ok || txq.size() != 0 || led[14:12] !== 3'd0 || sev_out !== 7'h78) begin
      err_cnt++; $display("FAIL prog_after: frames=%0d state=%0d sev=%h want 0 0 78", txq.size(), led[14:12], sev_out);
    end
  endtask

  task automatic test_rst_mid;
    send_byte(8'h00, 1'b1, BIT);
    repeat (10) @(negedge clk);
    vec_cnt++;
    if (led[14:12] !== 3'd1) begin
      err_cnt++; $display("FAIL rst_pre: state=%0d want 1", led[14:12]);
    end
    rx = 1'b0;
    repeat (100) @(negedge clk);
    Rst = 1'b1;
    #1;
    vec_cnt++;
    if (tx !== 1'b1 || led !== 16'h0000 || an !== 8'hFE || sev_out !== 7'h40 || clk_out !== 1'b0) begin
      err_cnt++; $display("FAIL rst_mid: tx=%b led=%h an=%h sev=%h clk_out=%b want 1 0000 fe 40 0", tx, led, an, sev_out, clk_out);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    repeat (800) @(negedge clk);
    vec_cnt++;
    if (led !== 16'h0000) begin
      err_cnt++; $display("FAIL rst_after: led=%h want 0000", led);
    end
  endtask

  task automatic test_n_zero;
    bit ok;
    logic [8:0] got;
    for (int i = 0; i < 5; i++) send_byte(8'h00, 1'b1, BIT);
    wait_txq(1500, ok);
    got = ok ? txq.pop_front() : 9'h0;
    vec_cnt++;
    if (!ok || got !== 9'h100) begin
      err_cnt++; $display("FAIL nzero_byte: got %h want 100", got);
    end
    wait_state(3'd0, 300, ok);
    repeat (800) @(negedge clk);
    vec_cnt++;
    if (!ok || led[14:12] !== 3'd0 || txq.size() != 0) begin
      err_cnt++; $display("FAIL nzero_end: state=%0d frames=%0d want 0 0", led[14:12], txq.size());
    end
  endtask

  task automatic test_bad_stop;
    send_byte(8'h00, 1'b0, BIT);
    repeat (50) @(negedge clk);
    vec_cnt++;
    if (led[14:12] !== 3'd0) begin
      err_cnt++; $display("FAIL badstop_state: state=%0d want 0", led[14:12]);
    end
    send_byte(8'hA5, 1'b0, BIT);
    repeat (50) @(negedge clk);
    vec_cnt++;
    if (led[7:0] !== 8'h00 || led[14:12] !== 3'd0) begin
      err_cnt++; $display("FAIL badstop_data: last=%h state=%0d want 00 0", led[7:0], led[14:12]);
    end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (1200) @(negedge clk);
    vec_cnt++;
    if (led[7:0] !== 8'h00 || led[14:12] !== 3'd0 || txq.size() != 0) begin
      err_cnt++; $display("FAIL glitch: last=%h state=%0d frames=%0d want 00 0 0", led[7:0], led[14:12], txq.size());
    end
  endtask

  initial begin
    test_reset();
    test_debug();
    test_countdown();
    test_ignore_scan();
    test_prog();
    test_rst_mid();
    test_n_zero();
    test_bad_stop();
    test_glitch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
